// File: rtl/if_ctrl_fsm.sv
// Purpose: CPU-facing request sequencer in front of a key/value cache controller.
// Latency: accepted op_wr_i -> ctrl_start_o next cycle; ctrl_done_i -> result_valid_o next cycle.
// Backpressure: one request in flight; op_wr_i in EXECUTE/WAIT is dropped, COMPLETE holds until ack or new op.
//
// Ports:
//   clk, rst_n                          clock / async active-low reset
//   op_wr_i, op_i, key_i, value_i       CPU request (op_wr_i strobes the request)
//   result_ack_i                        CPU consumed the result
//   ctrl_start_o, ctrl_op/key/value_o   one-cycle start plus latched request to the controller
//   ctrl_done_i, ctrl_hit_i, ctrl_value_i  controller completion and read data
//   state_o, busy_o                     FSM state and in-flight indication
//   result_valid/hit/value/err_o        latched result, valid while in COMPLETE
//
// Optional feature: define IF_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES.

package if_types_pkg;
  typedef enum logic [1:0] {
    IF_ST_IDLE     = 2'b00,
    IF_ST_EXECUTE  = 2'b01,
    IF_ST_WAIT     = 2'b10,
    IF_ST_COMPLETE = 2'b11
  } if_state_e;

  typedef enum logic [2:0] {
    IF_READ   = 3'd0,
    IF_UPSERT = 3'd1,
    IF_DELETE = 3'd2
  } request_operation_e;
endpackage

module if_ctrl_fsm
  import if_types_pkg::*;
#(
  parameter int KEY_W          = 16,
  parameter int VAL_W          = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_wr_i,
  input  logic [2:0]       op_i,
  input  logic [KEY_W-1:0] key_i,
  input  logic [VAL_W-1:0] value_i,
  input  logic             result_ack_i,
  output logic             ctrl_start_o,
  output logic [2:0]       ctrl_op_o,
  output logic [KEY_W-1:0] ctrl_key_o,
  output logic [VAL_W-1:0] ctrl_value_o,
  input  logic             ctrl_done_i,
  input  logic             ctrl_hit_i,
  input  logic [VAL_W-1:0] ctrl_value_i,
  output logic [1:0]       state_o,
  output logic             busy_o,
  output logic             result_valid_o,
  output logic             result_hit_o,
  output logic [VAL_W-1:0] result_value_o,
  output logic             result_err_o
);

  if_state_e        state_q, state_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic [2:0]       ctrl_op_q, ctrl_op_d;
  logic [KEY_W-1:0] ctrl_key_q, ctrl_key_d;
  logic [VAL_W-1:0] ctrl_val_q, ctrl_val_d;
  logic             res_hit_q, res_hit_d;
  logic [VAL_W-1:0] res_val_q, res_val_d;
  logic             res_err_q, res_err_d;
  logic             op_legal;

`ifdef IF_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Watchdog compiled out; the parameter stays so both builds share one interface.
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
`endif

  assign op_legal = (op_i == IF_READ) || (op_i == IF_UPSERT) || (op_i == IF_DELETE);

  always_comb begin
    state_d    = state_q;
    ctrl_op_d  = ctrl_op_q;
    ctrl_key_d = ctrl_key_q;
    ctrl_val_d = ctrl_val_q;
    res_hit_d  = res_hit_q;
    res_val_d  = res_val_q;
    res_err_d  = res_err_q;
`ifdef IF_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      // A new request in COMPLETE doubles as the ack, so both states share the accept path.
      IF_ST_IDLE, IF_ST_COMPLETE: begin
        if (op_wr_i) begin
          if (op_legal) begin
            state_d    = IF_ST_EXECUTE;
            ctrl_op_d  = op_i;
            ctrl_key_d = key_i;
            ctrl_val_d = value_i;
          end else begin
            state_d   = IF_ST_COMPLETE;
            res_err_d = 1'b1;
            res_hit_d = 1'b0;
            res_val_d = '0;
          end
        end else if ((state_q == IF_ST_COMPLETE) && result_ack_i) begin
          state_d = IF_ST_IDLE;
        end
      end
      IF_ST_EXECUTE: begin
        state_d = IF_ST_WAIT;
`ifdef IF_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      IF_ST_WAIT: begin
        // Completion is checked first so a done on the watchdog's last cycle still succeeds.
        if (ctrl_done_i) begin
          state_d   = IF_ST_COMPLETE;
          res_hit_d = ctrl_hit_i;
          res_err_d = 1'b0;
          res_val_d = (ctrl_op_q == IF_READ) ? ctrl_value_i : '0;
        end
`ifdef IF_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d   = IF_ST_COMPLETE;
          res_err_d = 1'b1;
          res_hit_d = 1'b0;
          res_val_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IF_ST_IDLE;
    endcase

    // Status outputs are registered off the next state so they line up with state_o.
    start_d = (state_d == IF_ST_EXECUTE);
    busy_d  = (state_d == IF_ST_EXECUTE) || (state_d == IF_ST_WAIT);
    valid_d = (state_d == IF_ST_COMPLETE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IF_ST_IDLE;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      ctrl_op_q  <= '0;
      ctrl_key_q <= '0;
      ctrl_val_q <= '0;
      res_hit_q  <= 1'b0;
      res_val_q  <= '0;
      res_err_q  <= 1'b0;
`ifdef IF_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      ctrl_op_q  <= ctrl_op_d;
      ctrl_key_q <= ctrl_key_d;
      ctrl_val_q <= ctrl_val_d;
      res_hit_q  <= res_hit_d;
      res_val_q  <= res_val_d;
      res_err_q  <= res_err_d;
`ifdef IF_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign state_o        = state_q;
  assign ctrl_start_o   = start_q;
  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign ctrl_op_o      = ctrl_op_q;
  assign ctrl_key_o     = ctrl_key_q;
  assign ctrl_value_o   = ctrl_val_q;
  assign result_hit_o   = res_hit_q;
  assign result_value_o = res_val_q;
  assign result_err_o   = res_err_q;

endmodule

// File: doc/if_ctrl_fsm.md
IF_CTRL_FSM -- requirements
Module: if_ctrl_fsm

Interface
REQ-001 SHALL have parameter KEY_W, default 16, key width.
REQ-002 SHALL have parameter VAL_W, default 64, value width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, WAIT-state watchdog limit; used only with IF_TIMEOUT_EN.
REQ-004 SHALL have one clock and an asynchronous active-low reset, as these ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- op_wr_i  in  1  CPU write strobe to the operation register.
- op_i  in  3  request_operation_e code.
- key_i  in  KEY_W  request key.
- value_i  in  VAL_W  request value.
- result_ack_i  in  1  CPU has read the result.
- ctrl_start_o  out  1  one-cycle start pulse to the cache controller.
- ctrl_op_o  out  3  latched operation.
- ctrl_key_o  out  KEY_W  latched key.
- ctrl_value_o  out  VAL_W  latched value.
- ctrl_done_i  in  1  controller completion strobe.
- ctrl_hit_i  in  1  key found; qualified by ctrl_done_i.
- ctrl_value_i  in  VAL_W  read data; qualified by ctrl_done_i.
- state_o  out  2  current if_state_e.
- busy_o  out  1  high in EXECUTE or WAIT.
- result_valid_o  out  1  high in COMPLETE.
- result_hit_o  out  1  latched hit.
- result_value_o  out  VAL_W  latched read value.
- result_err_o  out  1  illegal op or timeout.

Function
REQ-005 SHALL implement FSM states IF_ST_IDLE, IF_ST_EXECUTE, IF_ST_WAIT and IF_ST_COMPLETE from if_types_pkg.
REQ-006 IDLE: on op_wr_i with op_i in {IF_READ, IF_UPSERT, IF_DELETE}, SHALL latch op/key/value into ctrl_*_o and go to EXECUTE next cycle.
REQ-007 IDLE: on op_wr_i with op_i of 3..7, SHALL skip the controller, set result_err_o=1, result_hit_o=0, result_value_o=0, and go to COMPLETE.
REQ-008 EXECUTE: SHALL assert ctrl_start_o for exactly this one cycle, then go to WAIT unconditionally.
REQ-009 WAIT: on ctrl_done_i, SHALL latch ctrl_hit_i, clear result_err_o, and go to COMPLETE.
REQ-010 On that transition, result_value_o SHALL take ctrl_value_i for IF_READ and 0 for IF_UPSERT/IF_DELETE.
REQ-011 Latency SHALL be: op_wr_i at cycle 0 -> ctrl_start_o at cycle 1 -> WAIT at cycle 2; ctrl_done_i at cycle N -> result_valid_o at cycle N+1.
REQ-012 COMPLETE: result_ack_i SHALL return the FSM to IDLE; result_* outputs SHALL hold their values until the next capture.
REQ-013 COMPLETE: op_wr_i SHALL act as an implicit ack plus a new request, handled per REQ-006/007, and SHALL take priority over a simultaneous result_ack_i.
REQ-014 op_wr_i during EXECUTE or WAIT SHALL be ignored; ctrl_*_o SHALL stay stable until the next accepted request.
REQ-015 ctrl_done_i outside WAIT SHALL be ignored; ctrl_done_i in the same cycle as a timeout SHALL win.
REQ-016 result_ack_i outside COMPLETE SHALL be ignored.
REQ-017 Encodings 2'b00..2'b11 SHALL map to the states above; any unreachable encoding SHALL return to IDLE.

Reset
REQ-018 rst_n low SHALL immediately force state IDLE, with ctrl_start_o=0 and busy_o=0.
REQ-019 rst_n low SHALL immediately zero ctrl_op_o, ctrl_key_o, ctrl_value_o and the watchdog counter.
REQ-020 rst_n low SHALL immediately zero result_valid_o, result_hit_o, result_value_o and result_err_o.
REQ-021 Reset mid-transaction SHALL abandon the request with no further ctrl_start_o.
REQ-022 Deassertion SHALL be taken synchronously to clk.

Configuration
REQ-023 With IF_TIMEOUT_EN defined, a counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-024 With IF_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES without ctrl_done_i, the FSM SHALL go to COMPLETE with result_err_o=1, result_hit_o=0, result_value_o=0.
REQ-025 Without IF_TIMEOUT_EN, no counter SHALL exist and WAIT SHALL persist until ctrl_done_i.

Verification
REQ-026 IF_READ key 0x1234, done at cycle 5 with hit=1, value 0xDEADBEEF_CAFEF00D -> start only at cycle 1; result_valid_o at cycle 6; value and hit latched; err=0.
REQ-027 IF_UPSERT, done with ctrl_value_i=0xFFFF... -> result_value_o=0; result_ack_i -> IDLE next cycle.
REQ-028 op_i=3'd5 -> COMPLETE in 1 cycle, result_err_o=1, no ctrl_start_o.
REQ-029 op_wr_i in WAIT, then op_wr_i+IF_DELETE in COMPLETE with simultaneous result_ack_i -> first ignored; second goes to EXECUTE with key latched.
REQ-030 IF_TIMEOUT_EN, TIMEOUT_CYCLES=8, no done -> COMPLETE, err=1; done on the limit cycle instead -> err=0.
REQ-031 rst_n low during WAIT, then late ctrl_done_i -> IDLE, all outputs 0, done ignored.
